if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID latch.
- A DEPTH-entry instruction queue sits between the fetch stage and the decode stage, feeding a registered ID-side output.
- Fetch can keep running while decode is stalled, up to DEPTH entries, with explicit valid/ready backpressure.
- A branch flush clears the queue, and an empty queue bypasses straight to the output.

Parameters:
- ADDR_W, 32, width of instruction address.
- INST_W, 32, width of instruction word.
- DEPTH, 4, queue entries; power of two, at least 2.
- STALL_W, 6, width of the ctrl stall bus.
- STAGE_IDX, 1, index of the IF stall bit; the ID stall bit is STAGE_IDX+1, which must be less than STALL_W.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous reset, active-high.
- rdy, input, 1: global run enable; 0 freezes all state.
- stall_sign, input, STALL_W: ctrl stall bus.
- flush, input, 1: branch mispredict/redirect from EX.
- if_valid, input, 1: IF presents an instruction this cycle.
- if_pc, input, ADDR_W: fetched PC.
- if_inst, input, INST_W: fetched instruction.
- if_ready, output, 1: queue can accept a push; combinational from count only.
- id_valid, output, 1: id_pc/id_inst hold a real instruction.
- id_pc, output, ADDR_W: PC to ID.
- id_inst, output, INST_W: instruction to ID.
- q_count, output, clog2(DEPTH+1): current queue occupancy, registered.

Behaviour:
- Reset (rst=1 at posedge, regardless of rdy):
  - Outputs: id_valid=0, id_pc=0, id_inst=0, q_count=0.
  - Queue: head and tail pointers = 0.
- Priority at each posedge: rst > rdy=0 > flush > normal operation.
- rdy=0: every register holds its value. Pushes and pops are suppressed.
- flush=1 (rdy=1):
  - Queue emptied; q_count=0; pointers = 0.
  - id_valid=0, id_pc=0, id_inst=0.
  - A concurrent push is discarded.
- Control signals:
  - if_ready = (q_count != DEPTH). A full queue refuses a push even when a pop happens in the same cycle.
  - push = if_valid & if_ready & ~stall_sign[STAGE_IDX] & rdy & ~flush.
  - adv = ~stall_sign[STAGE_IDX+1]; this is the ID stage accepting a new instruction.
- Normal cycle, adv=1:
  - q_count>0: id_* <= queue head, id_valid <= 1, head pointer increments. If push is also high, the entry goes to the tail and q_count is unchanged.
  - q_count==0 and push: bypass; id_* <= if_pc/if_inst, id_valid <= 1, queue untouched. IF-to-ID latency is 1 cycle.
  - q_count==0 and no push: bubble; id_pc=0, id_inst=0, id_valid=0.
- Normal cycle, adv=0:
  - id_* and id_valid hold.
  - push writes to the tail; q_count+1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. q_count never exceeds DEPTH and never underflows.
- Order: FIFO; instructions reach ID in push order with no duplication or loss except on flush.
- Zero bubble is (pc=0, inst=0), which decodes as a NOP, consistent with existing ID handling.

Test Plan:
- Reset then idle, rdy=1, no stall → id_valid=0, id_inst=0, q_count=0, if_ready=1 every cycle.
- Push pc=0x100 inst=0x00000013 with an empty queue and no stall → next cycle id_pc=0x100, id_valid=1, q_count stays 0 (bypass).
- stall_sign[2]=1, push pc 0x0,0x4,0x8,0xC → q_count counts 1..4 and if_ready=0 at 4. A fifth push is held off by IF; id_* holds its prior value. Release the stall → ID receives 0x0,0x4,0x8,0xC on consecutive cycles and q_count goes 3,2,1,0.
- Queue at 2 entries, simultaneous push and pop → q_count stays 2; output order preserved across pointer wrap (run 10 entries through DEPTH=4).
- Queue at 3 entries, flush plus push in the same cycle → next cycle q_count=0, id_valid=0, id_pc=0; the pushed instruction never appears.
- Queue at 2 entries, rdy=0 for 3 cycles with if_valid=1 and no stall → all outputs and q_count frozen. Then rst=1 with rdy=0 → all outputs 0 on the next edge.

Source files
------------

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//
// Instruction queue between the fetch (IF) and decode (ID) stages. It
// replaces the single-entry IF/ID latch with a DEPTH-entry FIFO, so fetch
// can keep running while decode is stalled. The ID-side output
// (id_valid/id_pc/id_inst) is always registered. When the queue is empty,
// a fetched instruction bypasses the FIFO and reaches ID one cycle later.
//
// Priority at each clock edge: rst > rdy=0 > flush > normal operation.
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active-high (wins even when rdy=0)
//   rdy         global run enable; 0 freezes every register
//   stall_sign  ctrl stall bus; bit STAGE_IDX stalls IF, bit STAGE_IDX+1
//               stalls ID
//   flush       branch redirect from EX; empties the queue and the ID slot
//   if_valid    IF presents an instruction this cycle
//   if_pc       fetched PC
//   if_inst     fetched instruction word
//   if_ready    queue can take a push (depends on occupancy only)
//   id_valid    id_pc/id_inst carry a real instruction
//   id_pc       PC presented to ID (0 on a bubble)
//   id_inst     instruction presented to ID (0 on a bubble, a NOP)
//   q_count     registered queue occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int ADDR_W    = 32,
  parameter int INST_W    = 32,
  parameter int DEPTH     = 4,   // power of two, at least 2
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 1    // STAGE_IDX+1 must be below STALL_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic [STALL_W-1:0]           stall_sign,
  input  logic                         flush,
  input  logic                         if_valid,
  input  logic [ADDR_W-1:0]            if_pc,
  input  logic [INST_W-1:0]            if_inst,
  output logic                         if_ready,
  output logic                         id_valid,
  output logic [ADDR_W-1:0]            id_pc,
  output logic [INST_W-1:0]            id_inst,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // -------------------------------------------------------------------------
  // Storage and pointers
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PTR_W-1:0]  head;   // oldest entry, next to go to ID
  logic [PTR_W-1:0]  tail;   // next free slot

  // -------------------------------------------------------------------------
  // Per-cycle control
  // -------------------------------------------------------------------------
  logic             if_stall;
  logic             id_stall;
  logic             q_empty;
  logic             push;     // IF hands over an instruction this cycle
  logic             adv;      // ID takes a new instruction this cycle
  logic             pop;      // head entry moves to the ID register
  logic             bypass;   // empty queue: IF goes straight to ID
  logic             wr_en;    // push lands in the FIFO storage
  logic [CNT_W-1:0] count_n;

  // Only two bits of the stall bus concern this stage; the rest belong to
  // other stages. Folding them here keeps them visibly consumed.
  logic unused_stall;
  assign unused_stall = ^stall_sign;

  // NOTE: every signal driven in always_comb gets a default on the first
  // lines, so no path can leave it unassigned and infer a latch.
  always_comb begin
    if_stall = stall_sign[STAGE_IDX];
    id_stall = stall_sign[STAGE_IDX+1];
    q_empty  = (q_count == '0);

    // A full queue refuses a push even when it is popped the same cycle;
    // this keeps if_ready a pure function of the registered count.
    if_ready = (q_count != FULL_COUNT);

    push   = if_valid & if_ready & ~if_stall & rdy & ~flush;
    adv    = ~id_stall;
    pop    = adv & ~q_empty;
    bypass = adv & q_empty & push;
    wr_en  = push & ~bypass;

    count_n = q_count;
    if (wr_en && !pop) begin
      count_n = q_count + 1'b1;
    end else if (pop && !wr_en) begin
      count_n = q_count - 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage
  // -------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset. Its contents are
  // only observable through head/q_count, which are reset, so clearing
  // DEPTH entries of data would buy nothing.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_pc[tail]   <= if_pc;
      mem_inst[tail] <= if_inst;
    end
  end

  // -------------------------------------------------------------------------
  // Pointers, occupancy and the registered ID slot
  // -------------------------------------------------------------------------
  // NOTE: all state below is updated with non-blocking assignments so that
  // every right-hand side sees the pre-edge values (the head entry read
  // here is the one before this edge's pointer update).
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      q_count  <= '0;
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
    end else if (rdy) begin
      if (flush) begin
        // Redirect: drop everything in flight, including a concurrent push
        // (push is already gated off by flush).
        head     <= '0;
        tail     <= '0;
        q_count  <= '0;
        id_valid <= 1'b0;
        id_pc    <= '0;
        id_inst  <= '0;
      end else begin
        if (adv) begin
          if (!q_empty) begin
            // Oldest queued instruction goes first to keep FIFO order.
            id_valid <= 1'b1;
            id_pc    <= mem_pc[head];
            id_inst  <= mem_inst[head];
            head     <= head + 1'b1;
          end else if (push) begin
            // Empty queue: one-cycle IF-to-ID path, storage untouched.
            id_valid <= 1'b1;
            id_pc    <= if_pc;
            id_inst  <= if_inst;
          end else begin
            // Bubble: pc=0/inst=0 decodes as a NOP downstream.
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
          end
        end
        // With adv=0 the ID slot simply holds its value.

        if (wr_en) begin
          tail <= tail + 1'b1;
        end
        q_count <= count_n;
      end
    end
    // rdy=0: every register holds.
  end

endmodule
